// File: rtl/uart_receive.sv
// 8N1 UART receiver: oversamples the asynchronous RX line, frames characters
// and emits each good byte as a one-cycle valid pulse (stop-bit errors pulse urx_frame_err).
module uart_receive #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] urx_brx_data,
    output logic       urx_brx_valid,
    output logic       urx_frame_err
);

    localparam int BAUD_BIT_PERIOD = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;
    localparam int CW              = $clog2(BAUD_BIT_PERIOD);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_BIT_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

    generate
        if (BAUD_BIT_PERIOD < 4) begin : g_bad_rate
            $error("uart_receive: BAUD_BIT_PERIOD must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_sync;
    logic [CW-1:0]   baud_count;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    logic            count_clr;
    logic            bit_clr;
    logic            bit_shift;
    logic            byte_done;
    logic            stop_bad;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_wire_in;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sampling points: start bit at its middle, data/stop bits one full period apart.
    always_comb begin
        state_next = state;
        count_clr  = 1'b0;
        bit_clr    = 1'b0;
        bit_shift  = 1'b0;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                    count_clr  = 1'b1;
                end
            end
            START: begin
                if (baud_count == HALF_LAST) begin
                    count_clr = 1'b1;
                    if (rx_sync) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bit_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_count == BIT_LAST) begin
                    count_clr = 1'b1;
                    bit_shift = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_count == BIT_LAST) begin
                    state_next = IDLE;
                    if (rx_sync) begin
                        byte_done = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            baud_count <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
        end else begin
            if (count_clr) begin
                baud_count <= '0;
            end else if (state != IDLE) begin
                baud_count <= baud_count + 1'b1;
            end
            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (bit_shift) begin
                shift_reg[bit_idx] <= rx_sync;
                bit_idx            <= bit_idx + 3'd1;
            end
        end
    end

    // Valid-only output: no ready, the consumer must take the byte in the pulse cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            urx_brx_data  <= 8'h00;
            urx_brx_valid <= 1'b0;
            urx_frame_err <= 1'b0;
        end else begin
            urx_brx_valid <= byte_done;
            urx_frame_err <= stop_bad;
            if (byte_done) begin
                urx_brx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at 8 clocks per bit: vector table plus
// hand-written sequences for back-to-back, glitch and mid-byte reset.
module tb_uart_receive;

    localparam int CLK_F = 8_000_000;
    localparam int BAUD  = 1_000_000;
    localparam int BIT   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       err;

    uart_receive #(
        .CLOCK_FREQUENCY(CLK_F),
        .BAUD_RATE      (BAUD)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rx_wire_in   (rx),
        .urx_brx_data (data),
        .urx_brx_valid(valid),
        .urx_frame_err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         valid_cyc_q[$];
    logic       prev_v = 1'b0;
    logic       prev_e = 1'b0;

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic check_window(input string name, input int got, input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            valid_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got byte 0x%0h, expected no pulse", data);
            end else begin
                check("byte", int'(data), int'(exp_q.pop_front()));
                check_window("latency", cyc - start_q.pop_front(), 77, 79);
            end
            check("valid_err_exclusive", int'(err), 0);
            check("valid_width", int'(prev_v), 0);
        end
        if (err) begin
            n_err++;
            check("err_width", int'(prev_e), 0);
        end
        prev_v = valid;
        prev_e = err;
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        if (stop_bit) begin
            exp_q.push_back(d);
            start_q.push_back(cyc + 1);
        end
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            idle(BIT);
        end
        rx = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         nv0;
        int         ne0;
        int         base;
        logic [7:0] b77;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h11, 1'b1, 1, 0, 8'h11};
        vecs[4] = '{8'hFF, 1'b0, 0, 1, 8'h11};
        vecs[5] = '{8'h22, 1'b1, 1, 0, 8'h22};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;

        // Idle line for 200 cycles
        idle(200);
        check("idle_valid_count", n_valid, 0);
        check("idle_err_count", n_err, 0);
        check("idle_data", int'(data), 0);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            nv0 = n_valid;
            ne0 = n_err;
            send_frame(vecs[v].data, vecs[v].stop_bit);
            idle(20);
            check($sformatf("vec%0d_valid_count", v), n_valid - nv0, vecs[v].exp_valid);
            check($sformatf("vec%0d_err_count", v), n_err - ne0, vecs[v].exp_err);
            check($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
        end

        // Back-to-back characters
        base = valid_cyc_q.size();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("b2b_valid_count", valid_cyc_q.size() - base, 2);
        if (valid_cyc_q.size() - base == 2) begin
            check_window("b2b_spacing", valid_cyc_q[base + 1] - valid_cyc_q[base], 79, 81);
        end
        check("b2b_data", int'(data), 8'h5A);

        // Two-cycle low glitch, then a real character
        nv0 = n_valid;
        ne0 = n_err;
        rx  = 1'b0;
        idle(2);
        rx  = 1'b1;
        idle(20);
        check("glitch_valid_count", n_valid - nv0, 0);
        check("glitch_err_count", n_err - ne0, 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("post_glitch_valid_count", n_valid - nv0, 1);
        check("post_glitch_data", int'(data), 8'h3C);

        // Reset during data bit 4 of 0x77
        nv0 = n_valid;
        ne0 = n_err;
        b77 = 8'h77;
        rx  = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b77[i];
            idle(BIT);
        end
        rx = b77[4];
        idle(3);
        rst = 1'b1;
        #1;
        check("async_reset_data", int'(data), 0);
        check("async_reset_valid", int'(valid), 0);
        check("async_reset_err", int'(err), 0);
        idle(3);
        rst = 1'b0;
        rx  = 1'b1;
        idle(40);
        check("reset_drop_valid_count", n_valid - nv0, 0);
        check("reset_drop_err_count", n_err - ne0, 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("post_reset_valid_count", n_valid - nv0, 1);
        check("post_reset_data", int'(data), 8'h3C);

        check("expected_bytes_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial-to-byte front end for the LiDAR link. Oversamples the asynchronous RX line, frames 8N1 characters (1 start bit, 8 data bits LSB-first, no parity, 1 stop bit) and presents each good byte to the LiDAR protocol stage as a one-cycle valid pulse. It sits directly upstream of the protocol block and drives its `urx_brx_data` / `urx_brx_valid` inputs.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: system clock in Hz.
- `BAUD_RATE`, default 115200: line rate in bits/s.
- Derived: `BAUD_BIT_PERIOD = CLOCK_FREQUENCY / BAUD_RATE` (integer division, truncating; 868 at the defaults). `HALF_PERIOD = BAUD_BIT_PERIOD / 2`. `BAUD_BIT_PERIOD` must be ≥ 4; elaboration fails otherwise.
- `clk_in`  input  1  system clock; all state changes on its rising edge.
- `rst_in`  input  1  asynchronous, active-high reset.
- `rx_wire_in`  input  1  raw UART line, asynchronous to `clk_in`, idle high.
- `urx_brx_data`  output  8  last correctly framed byte.
- `urx_brx_valid`  output  1  one-cycle pulse: `urx_brx_data` holds a new byte.
- `urx_frame_err`  output  1  one-cycle pulse: the stop bit was sampled low and the byte was discarded.

## Operation
- `rx_wire_in` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the second flop, `rx_sync`.
- Two counters:
  - `baud_count`, width `$clog2(BAUD_BIT_PERIOD)`.
  - `bit_idx`, 3 bits.
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `rx_sync == 0`: go to START and clear `baud_count`.
  - Otherwise: stay in IDLE.
- **START** (increment `baud_count` each cycle)
  - At `baud_count == HALF_PERIOD-1`, sample `rx_sync`.
  - Sample 0: go to DATA, clear `baud_count` and `bit_idx`.
  - Sample 1: treat as a glitch and return to IDLE with no output.
- **DATA** (increment `baud_count` each cycle)
  - At `baud_count == BAUD_BIT_PERIOD-1`, shift `rx_sync` into bit `bit_idx` of the shift register (LSB first), clear `baud_count` and increment `bit_idx`.
  - After sampling bit 7, go to STOP.
- **STOP**
  - At `baud_count == BAUD_BIT_PERIOD-1`, sample `rx_sync`.
  - Sample 1: load `urx_brx_data` from the shift register and pulse `urx_brx_valid`.
  - Sample 0: pulse `urx_frame_err`; `urx_brx_data` is unchanged.
  - In both cases go to IDLE. This happens at mid-stop-bit, so a start bit immediately following is caught.
- The synchronizer keeps running in every state; no edge detection is performed outside IDLE.
- `urx_brx_data` changes only in the cycle `urx_brx_valid` rises, and holds until the next valid pulse or reset.
- `urx_brx_valid` and `urx_frame_err` are never high in the same cycle.
- There is no ready/backpressure. The consumer must accept the byte in the cycle `urx_brx_valid` is high.

## Timing
- **Reset** (asynchronous): takes effect immediately.
  - `urx_brx_data = 8'h00`, `urx_brx_valid = 0`, `urx_frame_err = 0`.
  - FSM returns to IDLE; both counters and the shift register are cleared; synchronizer flops go to 1.
- **Reset mid-byte:** the partial byte is dropped and no pulse is produced.
  - After release, a line already low is treated as a new start bit only if it is still low at the START mid-sample.
- **Latency:** `urx_brx_valid` is registered, so it rises 1 cycle after the STOP sample edge. Relative to the first rising edge at which the falling edge of `rx_wire_in` is seen by the first synchronizer flop, it rises `2 + HALF_PERIOD + 9*BAUD_BIT_PERIOD` cycles later, ±1 cycle. The verification bench must check against a window of ±1 cycle.
- **Pulse width:** `urx_brx_valid` and `urx_frame_err` are each high for exactly 1 cycle.
- **Back-to-back characters** (stop bit exactly one period, next start bit immediately after) are received without loss.
- **Glitches:** a low pulse shorter than about `HALF_PERIOD` cycles produces nothing.

## Test plan
Sim parameters: `CLOCK_FREQUENCY = 8_000_000`, `BAUD_RATE = 1_000_000`, giving `BAUD_BIT_PERIOD = 8` and `HALF_PERIOD = 4`.

1. Idle line held high for 200 cycles after reset -> `urx_brx_valid` and `urx_frame_err` stay 0; `urx_brx_data = 8'h00`.
2. Send 0xA5 at exactly 8 cycles/bit -> exactly one `urx_brx_valid` pulse, `urx_brx_data = 8'hA5`, latency 78 ±1 cycles from the start edge, `urx_frame_err` stays 0.
3. Send 0xA5 then 0x5A back-to-back with no idle between -> two valid pulses carrying 0xA5 then 0x5A, spaced 80 ±1 cycles apart.
4. Drive a low glitch of 2 cycles on an idle line -> no valid or error pulse; a following 0x3C is received correctly.
5. After receiving 0x11, send 0xFF with the stop bit driven low -> one `urx_frame_err` pulse, no valid pulse, `urx_brx_data` stays 8'h11; a following 0x22 is received correctly.
6. Assert `rst_in` for 3 cycles during data bit 4 of 0x77 -> outputs go to 0 asynchronously, no pulse for 0x77; a subsequent 0x3C yields `urx_brx_valid` with `urx_brx_data = 8'h3C`.
